// File: rtl/calc_display_ctrl.sv
// calc_display_ctrl
//   Display back-end for the calculator core. Digits streamed by the core
//   while it is printing go into a shadow buffer. When printing finishes
//   with status "ready", the whole frame is copied into the display buffer
//   in one step. Eight common-anode seven-segment displays are then
//   time-multiplexed from that buffer.
//
// Parameters
//   SCAN_DIV  clock cycles each digit stays lit (2 .. 2**20)
//   LZB       1 = blank leading zeros, 0 = show all eight digits
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous, active-low reset
//   status     core status: 00 error, 01 busy, 10 ready, 11 printing
//   data       digit value from the core (10..15 are stored but shown blank)
//   pos        core print index; 1..8 addresses shadow[pos-1]
//   an         active-low one-hot digit enable, bit 0 = units digit
//   seg        active-low segments {g,f,e,d,c,b,a}
//   frame_cnt  number of committed frames, wraps 255 -> 0
module calc_display_ctrl #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          LZB      = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_ERROR = 2'b00,
    ST_BUSY  = 2'b01,
    ST_READY = 2'b10,
    ST_PRINT = 2'b11
  } status_e;

  localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_O     = 7'b0100011;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [3:0]       shadow [8];
  logic [3:0]       disp   [8];
  logic [1:0]       prev_status;
  logic             err_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       idx_q;

  logic       wr_en;
  logic [2:0] wr_idx;
  logic       commit;
  logic       err_now;
  logic [2:0] top_nz;
  logic [6:0] seg_nxt;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'b1000000;
      4'd1:    encode = 7'b1111001;
      4'd2:    encode = 7'b0100100;
      4'd3:    encode = 7'b0110000;
      4'd4:    encode = 7'b0011001;
      4'd5:    encode = 7'b0010010;
      4'd6:    encode = 7'b0000010;
      4'd7:    encode = 7'b1111000;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0010000;
      default: encode = SEG_BLANK;
    endcase
  endfunction

  // pos 0 and pos > 8 must not alias onto a real slot through the 3-bit index.
  assign wr_en   = (status == ST_PRINT) && (pos != 4'd0) && (pos <= 4'd8);
  assign wr_idx  = 3'(pos - 4'd1);
  assign commit  = (prev_status == ST_PRINT) && (status != ST_PRINT);
  // The banner takes over on the same edge the error status is sampled.
  assign err_now = err_q || (status == ST_ERROR);

  // Highest display position holding a nonzero value; 0 when all are zero.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    top_nz = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (disp[i] != 4'd0) top_nz = 3'(i);
    end
  end

  always_comb begin
    seg_nxt = SEG_BLANK;
    if (err_now) begin
      case (idx_q)
        3'd0:        seg_nxt = SEG_O;
        3'd1, 3'd2:  seg_nxt = SEG_R;
        3'd3:        seg_nxt = SEG_E;
        default:     seg_nxt = SEG_BLANK;
      endcase
    end else if (LZB && (idx_q > top_nz)) begin
      seg_nxt = SEG_BLANK;
    end else begin
      seg_nxt = encode(disp[idx_q]);
    end
  end

  // NOTE: the two digit buffers are only 16 small registers and must read as
  // zero after reset, so they are reset like any other flop rather than left
  // as an unreset memory.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow      <= '{default: 4'd0};
      disp        <= '{default: 4'd0};
      prev_status <= ST_READY;
      err_q       <= 1'b0;
      div_q       <= '0;
      idx_q       <= 3'd0;
      frame_cnt   <= 8'd0;
      an          <= 8'hFF;
      seg         <= 7'h7F;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // right-hand side sees the pre-edge values.
      prev_status <= status;
      if (status == ST_ERROR) err_q <= 1'b1;

      if (!err_q) begin
        if (wr_en) shadow[wr_idx] <= data;
        if (commit) begin
          if (status == ST_READY) begin
            disp      <= shadow;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            shadow <= '{default: 4'd0};
          end
        end
      end

      if (div_q == DIV_LAST) begin
        div_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end

      an  <= ~(8'd1 << idx_q);
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_calc_display_ctrl.sv
// tb_calc_display_ctrl
//   Directed bench for calc_display_ctrl with SCAN_DIV=4. Two instances share
//   the same inputs: dut_a with leading-zero blanking, dut_b without.
module tb_calc_display_ctrl;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SR = 7'b0101111;
  localparam logic [6:0] SO = 7'b0100011;
  localparam logic [6:0] SB = 7'b1111111;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] status = 2'b10;
  logic [3:0] data = 4'd0;
  logic [3:0] pos = 4'd0;
  logic [7:0] an_a, an_b, fc_a, fc_b;
  logic [6:0] seg_a, seg_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  calc_display_ctrl #(.SCAN_DIV(4), .LZB(1'b1)) dut_a (
    .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
    .an(an_a), .seg(seg_a), .frame_cnt(fc_a)
  );

  calc_display_ctrl #(.SCAN_DIV(4), .LZB(1'b0)) dut_b (
    .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
    .an(an_b), .seg(seg_b), .frame_cnt(fc_b)
  );

  // Waits (bounded) until display i is lit on the chosen instance and returns its segments.
  task automatic grab(input bit inst_a, input int i, output logic [6:0] s, output bit ok);
    logic [7:0] want_an;
    want_an = 8'(~(8'd1 << i));
    ok = 1'b0;
    s  = SB;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clock);
      if ((inst_a ? an_a : an_b) === want_an) begin
        ok = 1'b1;
        s  = inst_a ? seg_a : seg_b;
      end
    end
  endtask

  // Streams one frame (hex nibble i = display i) with pos 1..8, optionally
  // followed by out-of-range writes of 8, then drops status to ready.
  task automatic print_frame(input logic [31:0] dig, input bit bounds);
    for (int p = 1; p <= 8; p++) begin
      status = 2'b11; pos = 4'(p); data = dig[4*(p-1) +: 4];
      @(negedge clock);
    end
    if (bounds) begin
      data = 4'd8;
      pos = 4'd0;  @(negedge clock);
      pos = 4'd9;  @(negedge clock);
      pos = 4'd15; @(negedge clock);
    end
    status = 2'b10; pos = 4'd0; data = 4'd0;
    @(negedge clock);
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    #1;
    n_vec++; if (an_a !== 8'hFF)  begin n_err++; $display("FAIL reset_an: got %h want ff", an_a); end
    n_vec++; if (seg_a !== 7'h7F) begin n_err++; $display("FAIL reset_seg: got %b want 1111111", seg_a); end
    n_vec++; if (fc_a !== 8'd0)   begin n_err++; $display("FAIL reset_cnt: got %0d want 0", fc_a); end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_vec++; if (an_a !== 8'hFE || seg_a !== S0)
        begin n_err++; $display("FAIL scan0_c%0d: got an=%h seg=%b want an=fe seg=%b", k, an_a, seg_a, S0); end
    end
    @(negedge clock);
    n_vec++; if (an_a !== 8'hFD || seg_a !== SB)
      begin n_err++; $display("FAIL scan1_lzb: got an=%h seg=%b want an=fd seg=%b", an_a, seg_a, SB); end
    n_vec++; if (an_b !== 8'hFD || seg_b !== S0)
      begin n_err++; $display("FAIL scan1_nolzb: got an=%h seg=%b want an=fd seg=%b", an_b, seg_b, S0); end
  endtask

  task automatic test_frame;
    logic [6:0] exp_a [8];
    logic [6:0] exp_b [8];
    logic [6:0] s;
    bit ok;
    exp_a = '{S3, S2, S1, SB, SB, SB, SB, SB};
    exp_b = '{S3, S2, S1, S0, S0, S0, S0, S0};
    print_frame(32'h0000_0123, 1'b0);
    n_vec++; if (fc_a !== 8'd1) begin n_err++; $display("FAIL frame_cnt1: got %0d want 1", fc_a); end
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      grab(1'b1, i, s, ok);
      n_vec++; if (!ok || s !== exp_a[i]) begin n_err++; $display("FAIL frame_lzb_d%0d: got %b (lit=%0d) want %b", i, s, ok, exp_a[i]); end
      grab(1'b0, i, s, ok);
      n_vec++; if (!ok || s !== exp_b[i]) begin n_err++; $display("FAIL frame_nolzb_d%0d: got %b (lit=%0d) want %b", i, s, ok, exp_b[i]); end
    end
  endtask

  task automatic test_partial;
    logic [6:0] s;
    bit ok;
    for (int p = 1; p <= 3; p++) begin
      status = 2'b11; pos = 4'(p); data = 4'd9;
      @(negedge clock);
    end
    status = 2'b01; pos = 4'd0; @(negedge clock);
    status = 2'b10; @(negedge clock);
    @(negedge clock);
    n_vec++; if (fc_a !== 8'd1) begin n_err++; $display("FAIL partial_cnt: got %0d want 1", fc_a); end
    grab(1'b1, 0, s, ok);
    n_vec++; if (!ok || s !== S3) begin n_err++; $display("FAIL partial_d0: got %b want %b", s, S3); end
    grab(1'b1, 2, s, ok);
    n_vec++; if (!ok || s !== S1) begin n_err++; $display("FAIL partial_d2: got %b want %b", s, S1); end

    print_frame(32'h0400_0506, 1'b0);
    n_vec++; if (fc_a !== 8'd2) begin n_err++; $display("FAIL next_cnt: got %0d want 2", fc_a); end
    @(negedge clock);
    grab(1'b1, 0, s, ok);
    n_vec++; if (!ok || s !== S6) begin n_err++; $display("FAIL next_d0: got %b want %b", s, S6); end
    grab(1'b1, 1, s, ok);
    n_vec++; if (!ok || s !== S0) begin n_err++; $display("FAIL next_d1: got %b want %b", s, S0); end
    grab(1'b1, 2, s, ok);
    n_vec++; if (!ok || s !== S5) begin n_err++; $display("FAIL next_d2: got %b want %b", s, S5); end
    grab(1'b1, 6, s, ok);
    n_vec++; if (!ok || s !== S4) begin n_err++; $display("FAIL next_d6: got %b want %b", s, S4); end
    grab(1'b1, 7, s, ok);
    n_vec++; if (!ok || s !== SB) begin n_err++; $display("FAIL next_d7: got %b want %b", s, SB); end
  endtask

  task automatic test_bounds;
    logic [6:0] exp_a [8];
    logic [6:0] exp_b [8];
    logic [6:0] s;
    bit ok;
    exp_a = '{S1, S0, S0, SB, S2, SB, SB, SB};
    exp_b = '{S1, S0, S0, SB, S2, S0, S0, S0};
    print_frame(32'h0002_C001, 1'b1);
    n_vec++; if (fc_a !== 8'd3) begin n_err++; $display("FAIL bounds_cnt: got %0d want 3", fc_a); end
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      grab(1'b1, i, s, ok);
      n_vec++; if (!ok || s !== exp_a[i]) begin n_err++; $display("FAIL bounds_lzb_d%0d: got %b (lit=%0d) want %b", i, s, ok, exp_a[i]); end
      grab(1'b0, i, s, ok);
      n_vec++; if (!ok || s !== exp_b[i]) begin n_err++; $display("FAIL bounds_nolzb_d%0d: got %b (lit=%0d) want %b", i, s, ok, exp_b[i]); end
    end
  endtask

  task automatic test_wrap;
    for (int f = 0; f < 253; f++) begin
      status = 2'b11; pos = 4'd1; data = 4'd1; @(negedge clock);
      status = 2'b10; pos = 4'd0; data = 4'd0; @(negedge clock);
      if (f == 251) begin
        n_vec++; if (fc_a !== 8'd255) begin n_err++; $display("FAIL wrap_255: got %0d want 255", fc_a); end
      end
    end
    n_vec++; if (fc_a !== 8'd0) begin n_err++; $display("FAIL wrap_0: got %0d want 0", fc_a); end
    n_vec++; if (fc_b !== 8'd0) begin n_err++; $display("FAIL wrap_0_b: got %0d want 0", fc_b); end
  endtask

  task automatic test_error;
    logic [6:0] exp_a [8];
    logic [6:0] s;
    bit ok;
    exp_a = '{SO, SR, SR, SE, SB, SB, SB, SB};
    status = 2'b00; @(negedge clock);
    status = 2'b10; @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      grab(1'b1, i, s, ok);
      n_vec++; if (!ok || s !== exp_a[i]) begin n_err++; $display("FAIL err_d%0d: got %b (lit=%0d) want %b", i, s, ok, exp_a[i]); end
    end
    grab(1'b0, 4, s, ok);
    n_vec++; if (!ok || s !== SB) begin n_err++; $display("FAIL err_nolzb_d4: got %b want %b", s, SB); end
    print_frame(32'h0000_0099, 1'b0);
    n_vec++; if (fc_a !== 8'd0) begin n_err++; $display("FAIL err_sticky_cnt: got %0d want 0", fc_a); end
    @(negedge clock);
    grab(1'b1, 0, s, ok);
    n_vec++; if (!ok || s !== SO) begin n_err++; $display("FAIL err_sticky_d0: got %b want %b", s, SO); end
  endtask

  task automatic test_reset_mid;
    logic [6:0] s;
    bit ok;
    reset = 1'b0; @(negedge clock);
    reset = 1'b1; @(negedge clock);
    print_frame(32'h0000_0007, 1'b0);
    n_vec++; if (fc_a !== 8'd1) begin n_err++; $display("FAIL post_err_cnt: got %0d want 1", fc_a); end
    @(negedge clock);
    grab(1'b1, 0, s, ok);
    n_vec++; if (!ok || s !== S7) begin n_err++; $display("FAIL post_err_d0: got %b want %b", s, S7); end
    grab(1'b1, 1, s, ok);
    n_vec++; if (!ok || s !== SB) begin n_err++; $display("FAIL post_err_d1: got %b want %b", s, SB); end
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    n_vec++; if (an_a !== 8'hFF)  begin n_err++; $display("FAIL mid_reset_an: got %h want ff", an_a); end
    n_vec++; if (seg_a !== 7'h7F) begin n_err++; $display("FAIL mid_reset_seg: got %b want 1111111", seg_a); end
    n_vec++; if (fc_a !== 8'd0)   begin n_err++; $display("FAIL mid_reset_cnt: got %0d want 0", fc_a); end
    repeat (3) @(negedge clock);
    n_vec++; if (an_b !== 8'hFF || seg_b !== 7'h7F)
      begin n_err++; $display("FAIL held_reset: got an=%h seg=%b want ff/1111111", an_b, seg_b); end
    reset = 1'b1;
  endtask

  initial begin
    test_reset;
    test_frame;
    test_partial;
    test_bounds;
    test_wrap;
    test_error;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calc_display_ctrl.md
# calc_display_ctrl

Display back-end for the calculator core. Consumes the core's `status`/`data`/`pos` digit stream, assembles an 8-digit frame in a shadow buffer, commits it atomically when the core finishes printing, and time-multiplexes eight common-anode seven-segment displays. It handles leading-zero blanking and an error banner, and sits directly downstream of the calculator core.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays lit; legal range 2..2^20.
- LZB, 1: 1 = leading-zero blanking enabled; 0 = all eight digits shown.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- status  in  2  core status: 00 error, 01 busy, 10 ready, 11 printing.
- data  in  4  digit value from the core, 0..9.
- pos  in  4  core print index, 0..8.
- an  out  8  digit enables, active-low, one-hot; bit i selects display i, where i=0 is the rightmost (units) digit.
- seg  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- frame_cnt  out  8  number of committed frames, wraps 255->0.

## Operation
- Shadow write:
  - Condition: status==11 and 1<=pos<=8.
  - Action: shadow[pos-1] <= data.
  - pos==0, or pos>8, writes nothing.
- Commit:
  - Condition: registered previous status is 11 and current status is not 11.
  - When current status is 10: display buffer <= shadow, and frame_cnt increments.
  - When current status is 00 or 01: shadow is discarded and the display buffer keeps its old frame.
- Error mode:
  - Entered when status==00; sticky until reset.
  - Display 3..0 show E,r,r,o. Displays 7..4 are blank.
  - No further writes or commits take effect.
- Leading-zero blanking (LZB=1):
  - Let h = the highest index with a nonzero digit in the display buffer (h=0 if all digits are zero).
  - Digits above h are blanked. Display 0 is never blanked.
- Scan:
  - Divider counts 0..SCAN_DIV-1.
  - On the terminal count, the divider returns to 0 and the scan index advances, wrapping 7->0.
- Output register:
  - an <= ~(1<<idx).
  - seg <= encode(displayed symbol at idx).
- Encoding (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - E=0000110, r=0101111, o=0100011, blank=1111111
  - data values 10..15 are stored as given and displayed as blank.
- Reset values:
  - an=8'hFF, seg=7'h7F, frame_cnt=0.
  - Shadow and display buffers all 0; scan index 0; divider 0; error flag 0; previous status register = 10.

## Timing
- Shadow write: one cycle after the qualifying input sample.
- Commit: the display buffer updates on the edge where the status change is sampled.
- Scan output lag: an/seg reflect the current scan index and buffer one cycle later. The first edge after reset release gives an=8'hFE with the encoded display-0 symbol.
- Error banner: appears on an/seg within 1 cycle of the scan reaching a digit after status==00 is sampled.
- Scan period: each digit is lit exactly SCAN_DIV cycles. A full refresh takes 8*SCAN_DIV cycles.
- Write and commit on the same edge: cannot both occur, because a commit requires status!=11.
- Reset mid-frame: all state returns to the reset values immediately (asynchronous). A partial shadow frame is lost.
- Input rate: inputs are sampled every cycle with no handshake. The core may present one digit per cycle.

## Test plan
- Reset release, SCAN_DIV=4:
  - an=FE, seg=1000000 (0) for 4 cycles.
  - Then an=FD, seg=1111111 (blanked leading zero).
- Print frame 00000123 (pos 1..8 with data 3,2,1,0,0,0,0,0, status=11, then status=10):
  - frame_cnt=1.
  - Displays 0,1,2 show 3,2,1; displays 3..7 are blank.
- Same frame with LZB=0: displays 3..7 show 0 (1000000).
- Partial frame, then status 11->01: display buffer unchanged and frame_cnt unchanged. The next full frame commits normally.
- status=00:
  - Displays 3..0 show E,r,r,o; 7..4 are blank.
  - A subsequent status=11 frame is ignored until reset, which is asserted low.
- Wrap and reset:
  - Commit 256 frames: frame_cnt returns to 0.
  - Assert reset low mid-scan: an=FF and seg=7F immediately, regardless of clock.
